// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MEM pipeline stages, the port arbiter and the shared memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IFReq;
    logic [ADDR_W-1:0] IFAddr;
    logic [DATA_W-1:0] IFRdata;
    logic              IFReady;

    logic              MEMReq;
    logic              MEMWe;
    logic [ADDR_W-1:0] MEMAddr;
    logic [DATA_W-1:0] MEMWdata;
    logic [DATA_W-1:0] MEMRdata;
    logic              MEMReady;

    logic              MemEn;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWdata;
    logic [DATA_W-1:0] MemRdata;

    logic              Stall;

    modport slave (
        input  IFReq, IFAddr, MEMReq, MEMWe, MEMAddr, MEMWdata, MemRdata,
        output IFRdata, IFReady, MEMRdata, MEMReady,
        output MemEn, MemWe, MemAddr, MemWdata, Stall
    );

    modport master (
        output IFReq, IFAddr, MEMReq, MEMWe, MEMAddr, MEMWdata, MemRdata,
        input  IFRdata, IFReady, MEMRdata, MEMReady,
        input  MemEn, MemWe, MemAddr, MemWdata, Stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF and MEM stages: one access in flight, Ready pulses
// MEM_LAT+1 cycles after issue; requesters are held via Stall until their Ready.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic Clk,
    input  logic Reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

    logic [1:0]        state_q, state_d;
    logic              owner_mem_q, owner_mem_d;
    logic              is_store_q, is_store_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_rdy_q, if_rdy_d;
    logic              mem_rdy_q, mem_rdy_d;

    logic starved;
    logic grant_if;
    logic issue;
    logic mem_store;

    assign starved   = (starve_q == STV_SAT);
    assign grant_if  = bus.IFReq & (~bus.MEMReq | starved);
    // Issue is blocked while Reset is high so no strobe escapes during an abort.
    assign issue     = (state_q == S_IDLE) & (bus.IFReq | bus.MEMReq) & ~Reset;
    assign mem_store = issue & ~grant_if & bus.MEMWe;

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        is_store_d  = is_store_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_rdy_d    = 1'b0;
        mem_rdy_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d     = S_WAIT;
                    owner_mem_d = ~grant_if;
                    is_store_d  = mem_store;
                    cnt_d       = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (owner_mem_q) begin
                        mem_rdy_d = 1'b1;
                        if (!is_store_q) mem_rdata_d = bus.MemRdata;
                    end else begin
                        if_rdy_d   = 1'b1;
                        if_rdata_d = bus.MemRdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counts MEM wins that bypassed a waiting fetch; IF is forced once it saturates.
    always_comb begin
        starve_d = starve_q;
        if (!bus.IFReq) begin
            starve_d = '0;
        end else if (issue && grant_if) begin
            starve_d = '0;
        end else if (issue && !starved) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            owner_mem_q <= 1'b0;
            is_store_q  <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_rdy_q    <= 1'b0;
            mem_rdy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            is_store_q  <= is_store_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_rdy_q    <= if_rdy_d;
            mem_rdy_q   <= mem_rdy_d;
        end
    end

    assign bus.MemEn    = issue;
    assign bus.MemWe    = mem_store;
    assign bus.MemAddr  = issue ? (grant_if ? bus.IFAddr : bus.MEMAddr) : '0;
    assign bus.MemWdata = mem_store ? bus.MEMWdata : '0;

    assign bus.IFRdata  = if_rdata_q;
    assign bus.IFReady  = if_rdy_q;
    assign bus.MEMRdata = mem_rdata_q;
    assign bus.MEMReady = mem_rdy_q;

    assign bus.Stall = (bus.IFReq & ~if_rdy_q) | (bus.MEMReq & ~mem_rdy_q);
endmodule
